// File: rtl/pcie_dma_wr_sequencer_pkg.sv
// Shared constants and types for the upstream DMA-write sequencer, its register decoder and bench.
package pcie_dma_pkg;

   typedef enum logic [1:0] {IDLE, DATA, TOKEN} dma_state_e;

   localparam int unsigned TLP_QWS = 16;
   localparam int unsigned BEAT_W  = $clog2(TLP_QWS);
   localparam int unsigned LEN_W   = 5;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned IDX_W   = 4;

   localparam logic [IDX_W-1:0]  REG_DMABASE        = 4'd0;
   localparam logic [IDX_W-1:0]  REG_DMACTRL        = 4'd1;
   localparam logic [ADDR_W-1:0] DATA_OFS           = 32'h40;
   localparam logic [ADDR_W-1:0] TLP_BYTES          = 32'(TLP_QWS * 8);
   localparam logic [DATA_W-1:0] DMA_COMPLETE_TOKEN = 64'hCAFEF00DC0DEFACE;

endpackage

// File: rtl/pcie_dma_wr_sequencer_if.sv
// Register-write, source-FIFO and TX-beat signals between decoder/FIFO, sequencer and formatter.
interface pcie_dma_wr_sequencer_if;
   import pcie_dma_pkg::*;

   logic                reg_wr_valid;
   logic [IDX_W-1:0]    reg_wr_index;
   logic [31:0]         reg_wr_data;
   logic [DATA_W-1:0]   src_data;
   logic                src_valid;
   logic                src_ready;
   logic                tx_valid;
   logic                tx_ready;
   logic                tx_sop;
   logic                tx_eop;
   logic [ADDR_W-1:0]   tx_addr;
   logic [LEN_W-1:0]    tx_len_qw;
   logic [DATA_W-1:0]   tx_data;

   modport master (
      input  reg_wr_valid, reg_wr_index, reg_wr_data, src_data, src_valid, tx_ready,
      output src_ready, tx_valid, tx_sop, tx_eop, tx_addr, tx_len_qw, tx_data
   );

   modport slave (
      output reg_wr_valid, reg_wr_index, reg_wr_data, src_data, src_valid, tx_ready,
      input  src_ready, tx_valid, tx_sop, tx_eop, tx_addr, tx_len_qw, tx_data
   );

endinterface

// File: rtl/pcie_dma_wr_sequencer.sv
// Streams DMACTRL[15:0] 128-byte MWr TLPs from the source FIFO, then one completion-token QW at DMABASE.
module pcie_dma_wr_sequencer
   import pcie_dma_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     rstn,
   pcie_dma_wr_sequencer_if.master  bus,
   output logic                     dma_busy,
   output logic                     dma_done
);

   dma_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   tok_q, tok_d;
   logic [ADDR_W-1:0]   work_q, work_d;
   logic [CNT_W-1:0]    left_q, left_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wr_base, wr_ctrl, last_beat;

   assign wr_base   = bus.reg_wr_valid && (bus.reg_wr_index == REG_DMABASE);
   assign wr_ctrl   = bus.reg_wr_valid && (bus.reg_wr_index == REG_DMACTRL);
   assign last_beat = (beat_q == BEAT_W'(TLP_QWS - 1));

   assign dma_busy = busy_q;
   assign dma_done = done_q;

   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         base_q  <= '0;
         tok_q   <= '0;
         work_q  <= '0;
         left_q  <= '0;
         beat_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         tok_q   <= tok_d;
         work_q  <= work_d;
         left_q  <= left_d;
         beat_q  <= beat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state and the zero-latency source-to-TX pass-through.
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      tok_d         = tok_q;
      work_d        = work_q;
      left_d        = left_q;
      beat_d        = beat_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      bus.src_ready = 1'b0;
      bus.tx_valid  = 1'b0;
      bus.tx_sop    = 1'b0;
      bus.tx_eop    = 1'b0;
      bus.tx_addr   = '0;
      bus.tx_len_qw = '0;
      bus.tx_data   = '0;

      if (wr_base) begin
         base_d = {bus.reg_wr_data[31:3], 3'b000};
      end

      case (state_q)
         IDLE: begin
            if (wr_ctrl) begin
               left_d  = bus.reg_wr_data[CNT_W-1:0];
               tok_d   = base_q;
               work_d  = base_q + DATA_OFS;
               beat_d  = '0;
               busy_d  = 1'b1;
               state_d = (bus.reg_wr_data[CNT_W-1:0] != '0) ? DATA : TOKEN;
            end
         end
         DATA: begin
            bus.tx_valid  = bus.src_valid;
            bus.src_ready = bus.tx_ready;
            bus.tx_data   = bus.src_data;
            bus.tx_sop    = (beat_q == '0);
            bus.tx_eop    = last_beat;
            bus.tx_addr   = work_q;
            bus.tx_len_qw = LEN_W'(TLP_QWS);
            if (bus.src_valid && bus.tx_ready) begin
               if (last_beat) begin
                  beat_d = '0;
                  work_d = work_q + TLP_BYTES;
                  left_d = left_q - CNT_W'(1);
                  if (left_q == CNT_W'(1)) begin
                     state_d = TOKEN;
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         TOKEN: begin
            bus.tx_valid  = 1'b1;
            bus.tx_sop    = 1'b1;
            bus.tx_eop    = 1'b1;
            bus.tx_addr   = tok_q;
            bus.tx_len_qw = LEN_W'(1);
            bus.tx_data   = DMA_COMPLETE_TOKEN;
            if (bus.tx_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
